// File: rtl/button_pkg.sv
// button_pkg: shared channel state, default timing constants and button indices
// for the button conditioner (auto-repeat enabled by BTN_REPEAT_EN).
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } btnState_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY    = 256;
    localparam int DEF_REPEAT_PERIOD   = 64;

    localparam int UP    = 0;
    localparam int RIGHT = 1;
    localparam int DOWN  = 2;
    localparam int LEFT  = 3;

    // Wide enough for the largest compare target so the counter never has to wrap.
    function automatic int cntWidth(input int d, input int rd, input int rp);
        int m;
        m = d > rd ? d : rd;
        m = m > rp ? m : rp;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser, debounce FSM and press strobe for one button.
// Defining BTN_REPEAT_EN adds auto-repeat strobes while the button stays held.
module debounce_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btnIn,
    output logic btnLevel,
    output logic btnPulse
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          sync1;
    logic          s;
    btnState_t     state;
    btnState_t     stateNext;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cntNext;
    logic [CW-1:0] cntInc;
    logic          pulseNext;

`ifdef BTN_REPEAT_EN
    localparam logic [CW-1:0] RD_TGT = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_TGT = CW'(REPEAT_PERIOD);
    logic rptPhase;
    logic rptPhaseNext;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= btnIn;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            btnPulse <= 1'b0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            btnPulse <= pulseNext;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rptPhase <= 1'b0;
        else
            rptPhase <= rptPhaseNext;
    end
`endif

    assign cntInc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pulseNext = 1'b0;
`ifdef BTN_REPEAT_EN
        rptPhaseNext = rptPhase;
`endif
        case (state)
            IDLE: begin
                if (s) begin
                    stateNext = PRESS_WAIT;
                    cntNext   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    stateNext = IDLE;
                end else if (cnt == DB_LAST) begin
                    stateNext = HELD;
                    pulseNext = 1'b1;
                    cntNext   = CNT_ONE;
`ifdef BTN_REPEAT_EN
                    rptPhaseNext = 1'b0;
`endif
                end else begin
                    cntNext = cntInc;
                end
            end
            HELD: begin
                if (!s) begin
                    stateNext = RELEASE_WAIT;
                    cntNext   = CNT_ONE;
                end
`ifdef BTN_REPEAT_EN
                // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                else if (cnt == (rptPhase ? RP_TGT : RD_TGT)) begin
                    pulseNext    = 1'b1;
                    cntNext      = CNT_ONE;
                    rptPhaseNext = 1'b1;
                end else begin
                    cntNext = cntInc;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (s) begin
                    stateNext = HELD;
                    cntNext   = CNT_ONE;
`ifdef BTN_REPEAT_EN
                    rptPhaseNext = 1'b0;
`endif
                end else if (cnt == DB_LAST) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cntInc;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign btnLevel = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_BTN independent debounced button channels with press strobes.
// Auto-repeat strobes are built only when BTN_REPEAT_EN is defined.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : gCh
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) uCh (
            .clk     (clk),
            .reset   (reset),
            .btnIn   (btn_in[i]),
            .btnLevel(btn_level[i]),
            .btnPulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus against a run-length model of the debouncer,
// compared every cycle, plus literal expectations (repeat counts follow BTN_REPEAT_EN).
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef BTN_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    // Model: the debouncer sees the input two edges late; a level flips once the
    // delayed input has disagreed with it for D consecutive edges.
    logic [3:0] p1, p2, mL, mP;
    int         run  [4];
    int         held [4];
    logic       sv;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1 = '0; p2 = '0; mL = '0; mP = '0;
            for (int i = 0; i < 4; i++) begin
                run[i]  = 0;
                held[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                sv    = p2[i];
                mP[i] = 1'b0;
                if (sv != mL[i]) begin
                    run[i]++;
                    held[i] = 0;
                    if (run[i] == D) begin
                        mL[i]  = sv;
                        run[i] = 0;
                        mP[i]  = sv;
                    end
                end else begin
                    held[i] = (mL[i] && run[i] == 0) ? held[i] + 1 : 0;
                    run[i]  = 0;
                    if (REP && mL[i] && (held[i] == RD || (held[i] > RD && (held[i] - RD) % RP == 0)))
                        mP[i] = 1'b1;
                end
            end
            p2 = p1;
            p1 = btn_in;
        end
    end

    always @(negedge clk) begin
        checks++;
        if (btn_level !== mL || btn_pulse !== mP) begin
            errors++;
            $display("FAIL cycle_compare t=%0t level=%b expected %b pulse=%b expected %b",
                     $time, btn_level, mL, btn_pulse, mP);
        end
    end

    int pc [4];
    int lh [4];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0;
            lh[i] = 0;
        end
    endtask

    // Drive v, then observe n edges (sampling 2 time units after each edge).
    task automatic drive(input logic [3:0] v, input int n);
        btn_in = v;
        repeat (n) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                pc[i] += int'(btn_pulse[i]);
                lh[i] += int'(btn_level[i]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 4'h0;
        clr();
        repeat (2) @(posedge clk);
        #2;
        check("reset_level", int'(btn_level), 0);
        check("reset_pulse", int'(btn_pulse), 0);
        reset = 1'b0;
        drive(4'h0, 3);

        drive(4'hF, 5);
        check("all_press_pre", int'(btn_pulse), 0);
        drive(4'hF, 1);
        check("all_press_pulse", int'(btn_pulse), 15);
        drive(4'hF, 1);
        check("all_press_after", int'(btn_pulse), 0);
        check("all_press_level", int'(btn_level), 15);

        #1 reset = 1'b1;
        #1;
        check("async_reset_level", int'(btn_level), 0);
        check("async_reset_pulse", int'(btn_pulse), 0);
        drive(4'hF, 3);
        reset = 1'b0;
        clr();
        drive(4'hF, 5);
        check("rst_held_pre", int'(btn_pulse), 0);
        drive(4'hF, 1);
        check("rst_held_pulse", int'(btn_pulse), 15);
        drive(4'hF, 6);
        for (int i = 0; i < 4; i++) check("rst_held_count", pc[i], 1);
        drive(4'h0, 5);
        check("all_release_hold", int'(btn_level), 15);
        drive(4'h0, 1);
        check("all_release_fall", int'(btn_level), 0);
        drive(4'h0, 5);

        clr();
        drive(4'h1, 40);
        drive(4'h0, 5);
        check("clean_level_hold", int'(btn_level[0]), 1);
        drive(4'h0, 1);
        check("clean_level_fall", int'(btn_level[0]), 0);
        check("clean_pulses", pc[0], REP ? 4 : 1);
        drive(4'h0, 4);

        clr();
        drive(4'h2, 1);
        drive(4'h0, 1);
        drive(4'h2, 2);
        drive(4'h0, 1);
        drive(4'h2, 5);
        check("bounce_no_early", pc[1], 0);
        drive(4'h2, 1);
        check("bounce_pulse", int'(btn_pulse[1]), 1);
        drive(4'h2, 6);
        drive(4'h0, 8);
        check("bounce_count", pc[1], 1);

        clr();
        drive(4'h4, 3);
        drive(4'h0, 10);
        check("glitch_pulses", pc[2], 0);
        check("glitch_level", lh[2], 0);

        clr();
        drive(4'h1, 10);
        drive(4'h0, 2);
        drive(4'h1, 8);
        drive(4'h0, 8);
        check("relbounce_pulses", pc[0], 1);
        check("relbounce_level_cycles", lh[0], 20);

        clr();
        drive(4'h5, 5);
        drive(4'h5, 1);
        check("simul_pulse", int'(btn_pulse), 5);
        drive(4'h5, 4);
        drive(4'h0, 8);

        clr();
        drive(4'h8, 63);
        drive(4'h0, 10);
        check("repeat_pulses", pc[3], REP ? 6 : 1);
        check("repeat_quiet", int'(btn_level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
